// File: rtl/safe_sync_ctrl.sv
// safe_sync_ctrl: global lockstep-entry sequencer for NHARTS harts.
// Drives halt / sync interrupts and bus merge, votes per-hart status
// against a TMR majority or DMR all-enabled quorum, and enforces a
// bounded dwell in every wait state.

// Per-hart slice: masks status with the latched enable and decodes
// this hart's interrupt lines from the global state.
module safe_sync_ctrl_lane (
  input  logic en,
  input  logic mst,
  input  logic halt_ack,
  input  logic wfi,
  input  logic intc_ack,
  input  logic st_halt,
  input  logic st_intr,
  input  logic st_end,
  output logic vote_halt,
  output logic vote_wfi,
  output logic vote_intc,
  output logic mst_intc,
  output logic irq_halt,
  output logic irq_sync
);
  // The master counts as halted: it requested the sync, so it needs no ack.
  assign vote_halt = en & (halt_ack | mst);
  assign vote_wfi  = en & wfi;
  assign vote_intc = en & intc_ack;
  assign mst_intc  = mst & intc_ack;
  assign irq_halt  = st_halt & en & ~mst;
  assign irq_sync  = (st_intr & en) | (st_end & mst);
endmodule

module safe_sync_ctrl #(
  parameter int NHARTS         = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              safe_mode_i,
  input  logic              safe_configuration_i,
  input  logic [NHARTS-1:0] hart_en_i,
  input  logic [NHARTS-1:0] master_core_i,
  input  logic [NHARTS-1:0] initial_sync_master_i,
  input  logic [NHARTS-1:0] halt_ack_i,
  input  logic [NHARTS-1:0] hart_wfi_i,
  input  logic [NHARTS-1:0] hart_intc_ack_i,
  output logic [NHARTS-1:0] interrupt_halt_o,
  output logic [NHARTS-1:0] interrupt_sync_o,
  output logic              single_bus_o,
  output logic              sync_error_o,
  output logic              busy_o
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_HALT_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT_WFI  = 3'd2;
  localparam logic [2:0] S_INTR_SYNC = 3'd3;
  localparam logic [2:0] S_SYNC      = 3'd4;
  localparam logic [2:0] S_END_SYNC  = 3'd5;
  localparam logic [2:0] S_ERROR     = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mode_q;
  logic [NHARTS-1:0] en_q, mst_q;
  logic              latch;

  logic [NHARTS-1:0] vote_halt, vote_wfi, vote_intc, mst_intc;

  // Votes arrive pre-masked by en_q, so disabled harts never count.
  function automatic logic quorum(input logic [NHARTS-1:0] v,
                                  input logic [NHARTS-1:0] en,
                                  input logic              tmr);
    if (tmr) return $countones(v) >= ($countones(en) / 2 + 1);
    else     return v == en;
  endfunction

  for (genvar g = 0; g < NHARTS; g++) begin : g_lane
    safe_sync_ctrl_lane u_lane (
      .en        (en_q[g]),
      .mst       (mst_q[g]),
      .halt_ack  (halt_ack_i[g]),
      .wfi       (hart_wfi_i[g]),
      .intc_ack  (hart_intc_ack_i[g]),
      .st_halt   (state_q == S_HALT_REQ),
      .st_intr   (state_q == S_INTR_SYNC),
      .st_end    (state_q == S_END_SYNC),
      .vote_halt (vote_halt[g]),
      .vote_wfi  (vote_wfi[g]),
      .vote_intc (vote_intc[g]),
      .mst_intc  (mst_intc[g]),
      .irq_halt  (interrupt_halt_o[g]),
      .irq_sync  (interrupt_sync_o[g])
    );
  end

  logic start, bad_cfg, tmo, waiting;
  assign start   = safe_mode_i & |(initial_sync_master_i & master_core_i & hart_en_i);
  assign bad_cfg = ($countones(hart_en_i) < 2) | !$onehot(master_core_i) |
                   ((master_core_i & hart_en_i) != master_core_i);
  assign tmo     = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  assign waiting = (state_q == S_HALT_REQ) | (state_q == S_WAIT_WFI) |
                   (state_q == S_INTR_SYNC) | (state_q == S_END_SYNC);

  // Next-state and timeout counter; an exit condition beats the timeout.
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        latch   = 1'b1;
        state_d = bad_cfg ? S_ERROR : S_HALT_REQ;
      end
      S_HALT_REQ:  if (quorum(vote_halt, en_q, mode_q)) state_d = S_WAIT_WFI;
                   else if (tmo)                        state_d = S_ERROR;
      S_WAIT_WFI:  if (quorum(vote_wfi, en_q, mode_q))  state_d = S_INTR_SYNC;
                   else if (tmo)                        state_d = S_ERROR;
      S_INTR_SYNC: if (quorum(vote_intc, en_q, mode_q)) state_d = S_SYNC;
                   else if (tmo)                        state_d = S_ERROR;
      S_SYNC:      if (!safe_mode_i && quorum(vote_wfi, en_q, mode_q)) state_d = S_END_SYNC;
      S_END_SYNC:  if (|mst_intc)                       state_d = S_IDLE;
                   else if (tmo)                        state_d = S_ERROR;
      S_ERROR:     if (!safe_mode_i)                    state_d = S_IDLE;
      default:                                          state_d = S_IDLE;
    endcase
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (waiting)       cnt_d = cnt_q + CNT_W'(1);
  end

  // State, counter and configuration latched at sequence start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      en_q    <= '0;
      mst_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        mode_q <= safe_configuration_i;
        en_q   <= hart_en_i;
        mst_q  <= master_core_i;
      end
    end
  end

  assign single_bus_o = (state_q == S_INTR_SYNC) | (state_q == S_SYNC);
  assign sync_error_o = state_q == S_ERROR;
  assign busy_o       = state_q != S_IDLE;
endmodule

// File: tb/tb_safe_sync_ctrl.sv
// Bench for safe_sync_ctrl (4 harts, 8-cycle timeout): each stimulus
// step pushes the expected outputs; they are popped and compared
// after the following clock edge.
module tb_safe_sync_ctrl;
  localparam int N = 4;

  logic         clk_i = 1'b0, rst_i = 1'b1;
  logic         safe_mode_i = 0, safe_configuration_i = 0;
  logic [N-1:0] hart_en_i = '0, master_core_i = '0, initial_sync_master_i = '0;
  logic [N-1:0] halt_ack_i = '0, hart_wfi_i = '0, hart_intc_ack_i = '0;
  logic [N-1:0] interrupt_halt_o, interrupt_sync_o;
  logic         single_bus_o, sync_error_o, busy_o;

  safe_sync_ctrl #(.NHARTS(N), .TIMEOUT_CYCLES(8)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .safe_mode_i(safe_mode_i), .safe_configuration_i(safe_configuration_i),
    .hart_en_i(hart_en_i), .master_core_i(master_core_i),
    .initial_sync_master_i(initial_sync_master_i),
    .halt_ack_i(halt_ack_i), .hart_wfi_i(hart_wfi_i), .hart_intc_ack_i(hart_intc_ack_i),
    .interrupt_halt_o(interrupt_halt_o), .interrupt_sync_o(interrupt_sync_o),
    .single_bus_o(single_bus_o), .sync_error_o(sync_error_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string        tag;
    logic [N-1:0] ih, is;
    logic         sb, err, busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs are already set; clock once and score the registered outputs.
  task automatic step(input string tag, input logic [N-1:0] ih, input logic [N-1:0] is,
                      input logic sb, input logic err, input logic busy);
    exp_t e;
    exp_q.push_back('{tag, ih, is, sb, err, busy});
    @(posedge clk_i); #1;
    e = exp_q.pop_front();
    chk({e.tag, ".ih"},   32'(interrupt_halt_o), 32'(e.ih));
    chk({e.tag, ".is"},   32'(interrupt_sync_o), 32'(e.is));
    chk({e.tag, ".sb"},   32'(single_bus_o),     32'(e.sb));
    chk({e.tag, ".err"},  32'(sync_error_o),     32'(e.err));
    chk({e.tag, ".busy"}, 32'(busy_o),           32'(e.busy));
  endtask

  task automatic start_seq(input logic tmr, input logic [N-1:0] en, input logic [N-1:0] mst,
                           input logic [N-1:0] init);
    safe_mode_i = 1; safe_configuration_i = tmr;
    hart_en_i = en; master_core_i = mst; initial_sync_master_i = init;
    halt_ack_i = '0; hart_wfi_i = '0; hart_intc_ack_i = '0;
  endtask

  initial begin
    #1;
    step("reset", '0, '0, 0, 0, 0);
    rst_i = 0;
    step("idle", '0, '0, 0, 0, 0);

    // TMR, harts 0..2 enabled, master hart 0
    start_seq(1, 4'b0111, 4'b0001, 4'b0001);
    step("tmr_halt", 4'b0110, '0, 0, 0, 1);
    initial_sync_master_i = '0; halt_ack_i = 4'b0010;
    step("tmr_wfi", '0, '0, 0, 0, 1);
    hart_wfi_i = 4'b0011;
    step("tmr_intr", '0, 4'b0111, 1, 0, 1);
    hart_intc_ack_i = 4'b0111;
    step("tmr_sync", '0, '0, 1, 0, 1);
    hart_intc_ack_i = '0; hart_wfi_i = 4'b0111;
    step("tmr_sync_hold", '0, '0, 1, 0, 1);
    safe_mode_i = 0; hart_wfi_i = 4'b0011;
    step("tmr_end", '0, 4'b0001, 0, 0, 1);
    hart_intc_ack_i = 4'b0001;
    step("tmr_idle", '0, '0, 0, 0, 0);

    // DMR, harts 0..1 enabled: one WFI is not enough
    start_seq(0, 4'b0011, 4'b0001, 4'b0001);
    step("dmr_halt", 4'b0010, '0, 0, 0, 1);
    initial_sync_master_i = '0; halt_ack_i = 4'b0110;
    step("dmr_wfi", '0, '0, 0, 0, 1);
    hart_wfi_i = 4'b0101;
    step("dmr_wfi_hold", '0, '0, 0, 0, 1);
    hart_wfi_i = 4'b0011;
    step("dmr_intr", '0, 4'b0011, 1, 0, 1);
    hart_intc_ack_i = 4'b0011;
    step("dmr_sync", '0, '0, 1, 0, 1);
    rst_i = 1;
    step("sync_reset", '0, '0, 0, 0, 0);
    rst_i = 0;
    start_seq(0, 4'b0000, 4'b0000, 4'b0000);
    step("post_reset_idle", '0, '0, 0, 0, 0);

    // Timeout: 8 cycles in HALT_REQ without quorum
    start_seq(1, 4'b0111, 4'b0001, 4'b0001);
    step("to_enter", 4'b0110, '0, 0, 0, 1);
    initial_sync_master_i = '0;
    for (int i = 0; i < 7; i++) step("to_wait", 4'b0110, '0, 0, 0, 1);
    step("to_error", '0, '0, 0, 1, 1);
    step("to_error_hold", '0, '0, 0, 1, 1);
    safe_mode_i = 0;
    step("to_clear", '0, '0, 0, 0, 0);

    // Exit on the last allowed cycle wins over the timeout
    start_seq(1, 4'b0111, 4'b0001, 4'b0001);
    step("edge_enter", 4'b0110, '0, 0, 0, 1);
    initial_sync_master_i = '0;
    for (int i = 0; i < 7; i++) step("edge_wait", 4'b0110, '0, 0, 0, 1);
    halt_ack_i = 4'b0100;
    step("edge_exit", '0, '0, 0, 0, 1);
    rst_i = 1;
    step("edge_reset", '0, '0, 0, 0, 0);
    rst_i = 0;

    // Bad configurations at start
    start_seq(1, 4'b0001, 4'b0001, 4'b0001);
    step("cfg_one_hart", '0, '0, 0, 1, 1);
    safe_mode_i = 0;
    step("cfg_one_clear", '0, '0, 0, 0, 0);
    start_seq(1, 4'b0111, 4'b0011, 4'b0011);
    step("cfg_two_mst", '0, '0, 0, 1, 1);
    safe_mode_i = 0;
    step("cfg_two_clear", '0, '0, 0, 0, 0);

    // Dropping safe_mode mid-sequence does not abort
    start_seq(1, 4'b0111, 4'b0100, 4'b0100);
    step("nab_halt", 4'b0011, '0, 0, 0, 1);
    safe_mode_i = 0; initial_sync_master_i = '0; halt_ack_i = 4'b0001;
    step("nab_wfi", '0, '0, 0, 0, 1);
    hart_wfi_i = 4'b0110;
    step("nab_intr", '0, 4'b0111, 1, 0, 1);
    hart_intc_ack_i = 4'b0011;
    step("nab_sync", '0, '0, 1, 0, 1);
    hart_intc_ack_i = '0;
    step("nab_end", '0, 4'b0100, 0, 0, 1);
    hart_intc_ack_i = 4'b0100;
    step("nab_idle", '0, '0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/safe_sync_ctrl.md
SAFE_SYNC_CTRL -- requirements
Module: safe_sync_ctrl

Interface
REQ-001 SHALL have parameter NHARTS, default 3, number of harts under control (legal 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles allowed in any wait state (legal >= 2).
REQ-003 SHALL have parameter CNT_W, default $clog2(TIMEOUT_CYCLES)+1, timeout counter width.
REQ-004 SHALL have a single clock and a synchronous, active-high reset, with ports named per codebase as clk_i and rst_i.
REQ-005 clk_i  input  1  clock, all state on rising edge.
REQ-006 rst_i  input  1  synchronous active-high reset.
REQ-007 safe_mode_i  input  1  request safe (lockstep) operation.
REQ-008 safe_configuration_i  input  1  1 = TMR (majority quorum), 0 = DMR (all enabled harts).
REQ-009 hart_en_i  input  NHARTS  harts participating in redundancy.
REQ-010 master_core_i  input  NHARTS  one-hot master select.
REQ-011 initial_sync_master_i  input  NHARTS  master's request to start initial sync.
REQ-012 halt_ack_i, hart_wfi_i, hart_intc_ack_i  input  NHARTS each  per-hart halt ack, WFI status, interrupt ack.
REQ-013 interrupt_halt_o  output  NHARTS  halt interrupt to non-master enabled harts.
REQ-014 interrupt_sync_o  output  NHARTS  sync interrupt per hart.
REQ-015 single_bus_o  output  1  merge harts onto single bus.
REQ-016 sync_error_o  output  1  sticky timeout or quorum failure flag.
REQ-017 busy_o  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement one global FSM: IDLE, HALT_REQ, WAIT_WFI, INTR_SYNC, SYNC, END_SYNC, ERROR.
REQ-019 SHALL latch mode_q, en_q = hart_en_i, mst_q = master_core_i on the IDLE->HALT_REQ transition; all later decisions use latched values only.
REQ-020 IDLE->HALT_REQ when safe_mode_i=1 and |(initial_sync_master_i & master_core_i & hart_en_i)=1.
REQ-021 IDLE->ERROR (same cycle as latch) if popcount(hart_en_i)<2, or master_core_i not one-hot, or master not in hart_en_i.
REQ-022 quorum(v) defined: TMR -> popcount(v & en_q) >= popcount(en_q)/2+1 (integer division); DMR -> (v & en_q) == en_q.
REQ-023 HALT_REQ->WAIT_WFI when quorum(halt_ack_i | mst_q).
REQ-024 WAIT_WFI->INTR_SYNC when quorum(hart_wfi_i).
REQ-025 INTR_SYNC->SYNC when quorum(hart_intc_ack_i).
REQ-026 SYNC->END_SYNC when safe_mode_i=0 and quorum(hart_wfi_i); SYNC has no timeout.
REQ-027 END_SYNC->IDLE when |(hart_intc_ack_i & mst_q).
REQ-028 ERROR->IDLE when safe_mode_i=0; sync_error_o clears on that transition only.
REQ-029 Timeout counter SHALL clear on every state change and increment each cycle in HALT_REQ, WAIT_WFI, INTR_SYNC, END_SYNC; reaching TIMEOUT_CYCLES-1 without exit condition -> ERROR next cycle; exit condition wins when simultaneous.
REQ-030 Outputs SHALL be Moore, decoded from registered state and latched values only (no combinational input paths).
REQ-031 interrupt_halt_o = en_q & ~mst_q in HALT_REQ, else 0.
REQ-032 interrupt_sync_o = en_q in INTR_SYNC, mst_q in END_SYNC, else 0.
REQ-033 single_bus_o = 1 in INTR_SYNC and SYNC, else 0.
REQ-034 sync_error_o = 1 in ERROR, else 0.
REQ-035 Disabled harts (en_q=0) SHALL never receive interrupts and SHALL be ignored by quorum.
REQ-036 safe_mode_i deassertion in HALT_REQ/WAIT_WFI/INTR_SYNC SHALL not abort; sequence completes to SYNC then exits via REQ-026.

Reset
REQ-037 rst_i=1 at any clock edge SHALL force IDLE, counter 0, mode_q/en_q/mst_q 0, all outputs 0 on next cycle, including mid-sequence.
REQ-038 Reset SHALL take priority over all transitions.

Verification
REQ-039 NHARTS=3, TMR, en=111, master=001: initial_sync_master_i=001 -> HALT_REQ, interrupt_halt_o=110; halt_ack=010 -> WAIT_WFI next cycle; wfi=011 -> INTR_SYNC, interrupt_sync_o=111, single_bus_o=1.
REQ-040 NHARTS=4, DMR, en=0011, master=0001: wfi=0001 holds WAIT_WFI; wfi=0011 -> INTR_SYNC; interrupt_sync_o=0011.
REQ-041 TIMEOUT_CYCLES=8: stay in HALT_REQ with no ack -> ERROR after exactly 8 cycles, sync_error_o=1; safe_mode_i=0 -> IDLE, flag clears.
REQ-042 Exit condition on counter=TIMEOUT_CYCLES-1 cycle -> next state taken, no ERROR.
REQ-043 en=001 at start request -> ERROR next cycle; master_core_i=011 -> ERROR.
REQ-044 rst_i pulse during SYNC -> next cycle IDLE, single_bus_o=0, busy_o=0.
